// File: rtl/i_buf_ds_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : i_buf_ds_bank_if
// Description : Pad-side and fabric-side signal bundle for the differential
//               receiver bank.
//                 i_p / i_n    : positive / negative pad lines, WIDTH each
//                 i_en         : bank enable (CLK domain)
//                 i_fault_clr  : clear of all sticky fault flags (CLK domain)
//                 o_data       : registered, filtered channel data
//                 o_fault      : sticky per-channel invalid-pair flags
//               master = driver of pads/controls, slave = receiver bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface i_buf_ds_bank_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_p;
  logic [WIDTH-1:0] i_n;
  logic             i_en;
  logic             i_fault_clr;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_fault;

  modport master (
    output i_p, i_n, i_en, i_fault_clr,
    input  o_data, o_fault
  );

  modport slave (
    input  i_p, i_n, i_en, i_fault_clr,
    output o_data, o_fault
  );
endinterface
`default_nettype wire

// File: rtl/i_buf_ds_bank.sv
`default_nettype none
// ============================================================================
// Module      : i_buf_ds_bank
// Description : WIDTH-channel clocked differential input receiver bank.
//               Each pad pair is synchronised into clk, decoded (10 -> 1,
//               01 -> 0, anything else invalid), glitch-filtered and
//               registered. A persistently invalid pair raises a sticky,
//               clearable fault flag.
// Ports       : clk  - sampling clock
//               rst  - asynchronous active-high reset
//               bus  - i_buf_ds_bank_if.slave (pads, enable, fault clear,
//                      filtered data, fault flags)
// Revision    : 1.0 - initial release
// ============================================================================
module i_buf_ds_bank #(
  parameter int    WIDTH                    = 4,
  parameter int    SYNC_STAGES              = 2,
  parameter int    FILTER_CYCLES            = 3,
  parameter int    FAULT_CYCLES             = 8,
  parameter string WEAK_KEEPER              = "NONE",
  parameter string DIFFERENTIAL_TERMINATION = "TRUE"
) (
  input  wire logic         clk,
  input  wire logic         rst,
  i_buf_ds_bank_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // Parameter range checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_chk_width
    $fatal(1, "i_buf_ds_bank: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "i_buf_ds_bank: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_chk_filter
    $fatal(1, "i_buf_ds_bank: FILTER_CYCLES must be >= 1");
  end
  if (FAULT_CYCLES < 1) begin : g_chk_fault
    $fatal(1, "i_buf_ds_bank: FAULT_CYCLES must be >= 1");
  end
  if (WEAK_KEEPER != "NONE" && WEAK_KEEPER != "PULLUP" &&
      WEAK_KEEPER != "PULLDOWN") begin : g_chk_keeper
    $fatal(1, "i_buf_ds_bank: WEAK_KEEPER must be NONE, PULLUP or PULLDOWN");
  end
  if (DIFFERENTIAL_TERMINATION != "TRUE" &&
      DIFFERENTIAL_TERMINATION != "FALSE") begin : g_chk_term
    $fatal(1, "i_buf_ds_bank: DIFFERENTIAL_TERMINATION must be TRUE or FALSE");
  end

  // The weak keeper is a property of the pad cell: an undriven line settles to
  // the pulled level and the resulting code is decoded like any other (00/11
  // are invalid). Termination has no logical effect. Neither needs logic here.

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int IW = $clog2(FAULT_CYCLES + 1);
  localparam logic [CW-1:0] c_filt  = CW'(FILTER_CYCLES);
  localparam logic [IW-1:0] c_fault = IW'(FAULT_CYCLES);

  // ---------------------------------------------------------------------------
  // Synchronisers: one chain per pad line, free-running regardless of enable.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_p;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p <= '0;
      r_sync_n <= '0;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], bus.i_p};
      r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], bus.i_n};
    end
  end

  logic [WIDTH-1:0] w_o;
  logic [WIDTH-1:0] w_fault;

  // ---------------------------------------------------------------------------
  // Per-channel decode, filter and fault detection
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic          w_p;
    logic          w_n;
    logic          w_valid;
    logic          w_v;
    logic [CW-1:0] w_cnt_nxt;
    logic [IW-1:0] w_inv_nxt;
    logic          r_o;
    logic          r_cand;
    logic          r_fault;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_inv;

    assign w_p = r_sync_p[SYNC_STAGES-1][gi];
    assign w_n = r_sync_n[SYNC_STAGES-1][gi];

    // Unknown or equal lines fall to the default arm and read as invalid.
    always_comb begin
      w_valid = 1'b0;
      w_v     = 1'b0;
      case ({w_p, w_n})
        2'b10:   begin w_valid = 1'b1; w_v = 1'b1; end
        2'b01:   begin w_valid = 1'b1; w_v = 1'b0; end
        default: begin w_valid = 1'b0; w_v = 1'b0; end
      endcase
    end

    // A new candidate value restarts the agreement count at 1. r_cnt never
    // holds c_filt (it drops to 0 when reached), so the increment cannot wrap.
    assign w_cnt_nxt = (w_v == r_cand) ? r_cnt + 1'b1 : {{(CW-1){1'b0}}, 1'b1};
    assign w_inv_nxt = (r_inv == c_fault) ? r_inv : r_inv + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_o     <= 1'b0;
        r_cand  <= 1'b0;
        r_cnt   <= '0;
        r_inv   <= '0;
        r_fault <= 1'b0;
      end else if (!bus.i_en) begin
        r_o    <= 1'b0;
        r_cand <= 1'b0;
        r_cnt  <= '0;
        r_inv  <= '0;
        if (bus.i_fault_clr) r_fault <= 1'b0;
      end else begin
        if (w_valid) begin
          r_inv <= '0;
          if (w_v == r_o) begin
            r_cnt <= '0;
          end else begin
            r_cand <= w_v;
            if (w_cnt_nxt == c_filt) begin
              r_o   <= w_v;
              r_cnt <= '0;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end else begin
          r_cnt <= '0;
          r_inv <= w_inv_nxt;
        end
        // Clear dominates; a still-stuck channel re-flags on the next edge
        // because r_inv stays saturated.
        if (bus.i_fault_clr)
          r_fault <= 1'b0;
        else if (!w_valid && (w_inv_nxt == c_fault))
          r_fault <= 1'b1;
      end
    end

    assign w_o[gi]     = r_o;
    assign w_fault[gi] = r_fault;
  end

  assign bus.o_data  = w_o;
  assign bus.o_fault = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_i_buf_ds_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_buf_ds_bank
// Description : Self-checking bench for i_buf_ds_bank. Two instances share the
//               pad stimulus: default parameters and FILTER_CYCLES=1.
//               A behavioural model tracks both every cycle; directed
//               literal expectations pin latency, glitch, fault, enable and
//               reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_buf_ds_bank;
  localparam int W      = 4;
  localparam int SYNC   = 2;
  localparam int FILT   = 3;
  localparam int FAULTC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] p   = '0;
  logic [W-1:0] n   = '1;
  logic         en  = 1'b1;
  logic         fclr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i_buf_ds_bank_if #(.WIDTH(W)) ifa ();
  i_buf_ds_bank_if #(.WIDTH(W)) ifb ();

  assign ifa.i_p = p;  assign ifa.i_n = n;
  assign ifa.i_en = en; assign ifa.i_fault_clr = fclr;
  assign ifb.i_p = p;  assign ifb.i_n = n;
  assign ifb.i_en = en; assign ifb.i_fault_clr = fclr;

  i_buf_ds_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT),
                  .FAULT_CYCLES(FAULTC)) dut  (.clk(clk), .rst(rst), .bus(ifa));
  i_buf_ds_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .FILTER_CYCLES(1),
                  .FAULT_CYCLES(FAULTC)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the pad pair seen by the filter is the pad value SYNC edges ago.
  // O flips once FILTER consecutive valid decodes disagree with it; FAULT sets
  // once FAULTC consecutive invalid decodes have been seen.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mp [SYNC];
  logic [W-1:0] mn [SYNC];
  logic [W-1:0] m_o [2];
  logic [W-1:0] m_f [2];
  int           run [2][W];
  int           inv [2][W];

  function automatic int fc(input int k);
    return (k == 0) ? FILT : 1;
  endfunction

  task automatic model_step();
    logic dp, dn;
    if (rst) begin
      for (int s = 0; s < SYNC; s++) begin mp[s] = '0; mn[s] = '0; end
      for (int k = 0; k < 2; k++) begin
        m_o[k] = '0; m_f[k] = '0;
        for (int c = 0; c < W; c++) begin run[k][c] = 0; inv[k][c] = 0; end
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < W; c++) begin
        dp = mp[SYNC-1][c];
        dn = mn[SYNC-1][c];
        if (!en) begin
          m_o[k][c] = 1'b0; run[k][c] = 0; inv[k][c] = 0;
          if (fclr) m_f[k][c] = 1'b0;
        end else begin
          if (dp != dn) begin
            inv[k][c] = 0;
            if (dp == m_o[k][c]) run[k][c] = 0;
            else begin
              run[k][c]++;
              if (run[k][c] >= fc(k)) begin m_o[k][c] = dp; run[k][c] = 0; end
            end
          end else begin
            run[k][c] = 0;
            if (inv[k][c] < FAULTC) inv[k][c]++;
          end
          if (fclr) m_f[k][c] = 1'b0;
          else if (dp == dn && inv[k][c] == FAULTC) m_f[k][c] = 1'b1;
        end
      end
    end
    for (int s = SYNC - 1; s > 0; s--) begin mp[s] = mp[s-1]; mn[s] = mn[s-1]; end
    mp[0] = p; mn[0] = n;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        chk("model_fc3", {24'd0, ifa.o_fault, ifa.o_data}, {24'd0, m_f[0], m_o[0]});
        chk("model_fc1", {24'd0, ifb.o_fault, ifb.o_data}, {24'd0, m_f[1], m_o[1]});
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic setpair(input int ch, input logic [1:0] pn);
    p[ch] = pn[1];
    n[ch] = pn[0];
  endtask

  int lat0, lat1;

  initial begin
    // Reset state
    tick(2);
    chk("reset_o", {28'd0, ifa.o_data}, 32'h0);
    chk("reset_fault", {28'd0, ifa.o_fault}, 32'h0);
    rst = 1'b0;
    tick(4);

    // Latency: ch0 01 -> 10
    setpair(0, 2'b10);
    lat0 = 0; lat1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      if (lat0 == 0 && ifa.o_data[0]) lat0 = k;
      if (lat1 == 0 && ifb.o_data[0]) lat1 = k;
    end
    chk("latency_fc3", lat0, 32'd5);
    chk("latency_fc1", lat1, 32'd3);
    @(negedge clk);

    // Glitch reject on ch1
    setpair(1, 2'b10); tick(2);
    setpair(1, 2'b01); tick(6);
    chk("glitch2_o1", {31'd0, ifa.o_data[1]}, 32'd0);
    setpair(1, 2'b10); tick(6);
    chk("held3_o1", {31'd0, ifa.o_data[1]}, 32'd1);

    // Invalid hold and fault on ch2
    setpair(2, 2'b10); tick(6);
    chk("ch2_o_set", {31'd0, ifa.o_data[2]}, 32'd1);
    setpair(2, 2'b11); tick(9);
    chk("inv7_o2", {31'd0, ifa.o_data[2]}, 32'd1);
    chk("inv7_fault2", {31'd0, ifa.o_fault[2]}, 32'd0);
    tick(1);
    chk("inv8_fault2", {31'd0, ifa.o_fault[2]}, 32'd1);
    setpair(2, 2'b10); tick(5);
    chk("valid_fault2_sticky", {31'd0, ifa.o_fault[2]}, 32'd1);

    // Enable drop
    setpair(3, 2'b10); tick(6);
    chk("all_ones", {28'd0, ifa.o_data}, 32'hF);
    en = 1'b0; tick(1);
    chk("en0_o", {28'd0, ifa.o_data}, 32'h0);
    chk("en0_fault_hold", {28'd0, ifa.o_fault}, 32'h4);
    en = 1'b1; tick(2);
    chk("reen_2edges", {28'd0, ifa.o_data}, 32'h0);
    tick(1);
    chk("reen_3edges", {28'd0, ifa.o_data}, 32'hF);

    // FAULT_CLR on stuck ch3
    setpair(3, 2'b00); tick(10);
    chk("ch3_fault_set", {31'd0, ifa.o_fault[3]}, 32'd1);
    chk("ch3_o_hold", {31'd0, ifa.o_data[3]}, 32'd1);
    fclr = 1'b1; tick(1);
    chk("clr_fault3", {31'd0, ifa.o_fault[3]}, 32'd0);
    fclr = 1'b0; tick(1);
    chk("reflag_fault3", {31'd0, ifa.o_fault[3]}, 32'd1);
    setpair(3, 2'b10); tick(3);
    fclr = 1'b1; tick(1);
    chk("clr_valid_fault3", {31'd0, ifa.o_fault[3]}, 32'd0);
    fclr = 1'b0; tick(3);
    chk("stay_clear_fault", {28'd0, ifa.o_fault}, 32'h0);

    // Asynchronous reset mid-run with O=1010, FAULT=0001
    setpair(0, 2'b01); setpair(1, 2'b10); setpair(2, 2'b01); setpair(3, 2'b10);
    tick(6);
    fclr = 1'b1; tick(1); fclr = 1'b0;
    setpair(0, 2'b00); tick(10);
    chk("pre_rst_o", {28'd0, ifa.o_data}, 32'hA);
    chk("pre_rst_fault", {28'd0, ifa.o_fault}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("async_rst_o", {28'd0, ifa.o_data}, 32'h0);
    chk("async_rst_fault", {28'd0, ifa.o_fault}, 32'h0);
    tick(2);
    rst = 1'b0;
    setpair(0, 2'b01);
    tick(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
